// File: rtl/vram_wr_arbiter_pkg.sv
// vram_wr_arbiter_pkg: VRAM port-B geometry, write-master indices and arbiter state type
package vram_wr_arbiter_pkg;
  localparam int VRAM_ADDR_W = 18;
  localparam int PIX_W = 8;
  localparam int VRAM_TOTAL_BYTES = 98304;
  localparam int WR_CLEAR = 0;
  localparam int WR_RASTER = 1;
  localparam int WR_NREQ = WR_RASTER + 1;
  localparam int WR_MAX_BURST = 64;
  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/vram_wr_arbiter_rr_pick.sv
// vram_wr_arbiter_rr_pick: rotating-priority encoder, first set req at or after ptr wins
module vram_wr_arbiter_rr_pick #(
  parameter int N = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IDX_W'((int'(ptr) + k) % N);
      if (req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/vram_wr_arbiter.sv
// vram_wr_arbiter: round-robin, burst-bounded sharing of VRAM write port B among NREQ masters
module vram_wr_arbiter
  import vram_wr_arbiter_pkg::*;
#(
  parameter int NREQ = WR_NREQ,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = PIX_W,
  parameter int TOTAL_BYTES = VRAM_TOTAL_BYTES,
  parameter int MAX_BURST = WR_MAX_BURST,
  localparam int IDX_W = $clog2(NREQ),
  localparam int CNT_W = $clog2(MAX_BURST + 1)
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]        vram_addr_b,
  output logic [DATA_W-1:0]        vram_data_b,
  output logic                     vram_we_b,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy,
  output logic                     err_range
);
  arb_state_t state;
  logic [IDX_W-1:0] owner, rr_ptr, pick;
  logic [CNT_W-1:0] cnt;
  logic found, beat, last, in_range;
  logic [ADDR_W-1:0] addr;
  vram_wr_arbiter_rr_pick #(.N(NREQ)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .found(found),
    .idx(pick)
  );
  // ready depends only on state/owner so masters may wait on it without a comb loop
  assign req_ready = (state == GRANT) ? NREQ'(1) << owner : '0;
  assign beat = state == GRANT && req_valid[owner];
  assign last = cnt == CNT_W'(MAX_BURST - 1);
  assign addr = req_addr[owner*ADDR_W +: ADDR_W];
  assign in_range = 32'(addr) < TOTAL_BYTES;
  assign grant_id = owner;
  assign busy = state == GRANT || vram_we_b;
  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= IDX_W'(WR_CLEAR);
      cnt <= '0;
      vram_addr_b <= '0;
      vram_data_b <= '0;
      vram_we_b <= 1'b0;
      err_range <= 1'b0;
    end else begin
      vram_we_b <= beat && in_range;
      err_range <= beat && !in_range;
      if (beat) begin
        vram_addr_b <= addr;
        vram_data_b <= req_data[owner*DATA_W +: DATA_W];
        cnt <= cnt + 1'b1;
      end
      if (state == IDLE && !hold && found) begin
        owner <= pick;
        cnt <= '0;
        state <= GRANT;
      end
      if (state == GRANT && (!beat || last)) begin
        state <= IDLE;
        rr_ptr <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end
endmodule
